// File: rtl/switch_pkg.sv
// Shared definitions for the switch-box routing matrix and its configuration loader.
// Routing word: bits [2:0] select the source side, bits [5:3] the wire index on that side.
package switch_pkg;

   localparam int NTB    = 5;
   localparam int NLR    = 4;
   localparam int WORD_W = 6;
   localparam int NWORDS = 2 * NTB + 2 * NLR;

   localparam logic [7:0] SYNC = 8'hA5;

   localparam logic [2:0] SIDE_NONE   = 3'd0;
   localparam logic [2:0] SIDE_TOP    = 3'd1;
   localparam logic [2:0] SIDE_RIGHT  = 3'd2;
   localparam logic [2:0] SIDE_BOTTOM = 3'd3;
   localparam logic [2:0] SIDE_LEFT   = 3'd4;

   // Position of each edge's first word within the serial frame
   localparam int TOP_BASE    = 0;
   localparam int BOTTOM_BASE = NTB;
   localparam int LEFT_BASE   = 2 * NTB;
   localparam int RIGHT_BASE  = 2 * NTB + NLR;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CSUM  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

endpackage

// File: rtl/switch_cfg_loader_if.sv
// Serial configuration input and routing-word outputs of the loader.
// cfg_sen is a qualifier, not a handshake: a bit is consumed on every edge where it is 1; there is no backpressure.
interface switch_cfg_loader_if;
   import switch_pkg::*;

   logic                  cfg_sen;
   logic                  cfg_sdi;
   logic [NTB*WORD_W-1:0] cfg_top;
   logic [NTB*WORD_W-1:0] cfg_bottom;
   logic [NLR*WORD_W-1:0] cfg_left;
   logic [NLR*WORD_W-1:0] cfg_right;
   logic                  cfg_busy;
   logic                  cfg_done;
   logic                  cfg_err;
   state_t                dbg_state;

   modport master (
      output cfg_sen, cfg_sdi,
      input  cfg_top, cfg_bottom, cfg_left, cfg_right,
      input  cfg_busy, cfg_done, cfg_err, dbg_state
   );

   modport slave (
      input  cfg_sen, cfg_sdi,
      output cfg_top, cfg_bottom, cfg_left, cfg_right,
      output cfg_busy, cfg_done, cfg_err, dbg_state
   );

endinterface

// File: rtl/switch_word_check.sv
// Combinational legality check of one routing word for a matrix of the given edge sizes.
module switch_word_check
   import switch_pkg::*;
#(
   parameter int N_TOP_BOT    = NTB,
   parameter int N_LEFT_RIGHT = NLR
) (
   input  word_t word,
   output logic  legal
);

   logic [2:0] side;
   logic [2:0] idx;

   assign side = word[2:0];
   assign idx  = word[5:3];

   // Side 0 means "not driven", so its index field is don't-care
   always_comb begin
      legal = 1'b0;
      case (side)
         SIDE_NONE:             legal = 1'b1;
         SIDE_TOP, SIDE_BOTTOM: legal = (32'(idx) < N_TOP_BOT);
         SIDE_RIGHT, SIDE_LEFT: legal = (32'(idx) < N_LEFT_RIGHT);
         default:               legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial frame loader: hunts for SYNC, assembles 18 routing words into a shadow array,
// validates range and checksum, then commits all words to the matrix outputs in one cycle.
module switch_cfg_loader
   import switch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   switch_cfg_loader_if.slave   bus
);

   state_t     state, state_nx;
   logic [7:0] window, window_nx;
   word_t      word_sr, word_sr_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [4:0] word_cnt, word_cnt_nx;
   logic [7:0] sum, sum_nx;
   logic [7:0] csum_sr, csum_nx;
   logic       bad, bad_nx;
   logic       shadow_we;
   logic       commit;
   logic       reject;

   word_t      shadow [NWORDS];
   word_t      word_in;
   logic       word_legal;

   logic [NTB*WORD_W-1:0] top_q, bottom_q;
   logic [NLR*WORD_W-1:0] left_q, right_q;
   logic                  done_q, err_q;

   assign word_in = {word_sr[WORD_W-2:0], bus.cfg_sdi};

   switch_word_check #(
      .N_TOP_BOT    (NTB),
      .N_LEFT_RIGHT (NLR)
   ) u_check (
      .word  (word_in),
      .legal (word_legal)
   );

   always_comb begin
      state_nx    = state;
      window_nx   = window;
      word_sr_nx  = word_sr;
      bit_cnt_nx  = bit_cnt;
      word_cnt_nx = word_cnt;
      sum_nx      = sum;
      csum_nx     = csum_sr;
      bad_nx      = bad;
      shadow_we   = 1'b0;
      commit      = 1'b0;
      reject      = 1'b0;

      case (state)
         ST_HUNT: begin
            if (bus.cfg_sen) begin
               window_nx = {window[6:0], bus.cfg_sdi};
               // Window is cleared on lock so stale bits never combine with the next frame's SYNC
               if (window_nx == SYNC) begin
                  state_nx    = ST_DATA;
                  window_nx   = '0;
                  bit_cnt_nx  = '0;
                  word_cnt_nx = '0;
               end
            end
         end

         ST_DATA: begin
            if (bus.cfg_sen) begin
               word_sr_nx = word_in;
               if (bit_cnt == 3'(WORD_W - 1)) begin
                  shadow_we  = 1'b1;
                  sum_nx     = sum + 8'(word_in);
                  bad_nx     = bad | ~word_legal;
                  bit_cnt_nx = '0;
                  if (word_cnt == 5'(NWORDS - 1)) begin
                     state_nx    = ST_CSUM;
                     word_cnt_nx = '0;
                  end else begin
                     word_cnt_nx = word_cnt + 5'd1;
                  end
               end else begin
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end

         ST_CSUM: begin
            if (bus.cfg_sen) begin
               csum_nx = {csum_sr[6:0], bus.cfg_sdi};
               if (bit_cnt == 3'd7) begin
                  state_nx   = ST_CHECK;
                  bit_cnt_nx = '0;
               end else begin
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end

         ST_CHECK: begin
            if (!bad && (csum_sr == sum)) commit = 1'b1;
            else                          reject = 1'b1;
            state_nx    = ST_HUNT;
            bad_nx      = 1'b0;
            sum_nx      = '0;
            bit_cnt_nx  = '0;
            word_cnt_nx = '0;
         end

         default: state_nx = ST_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_HUNT;
         window   <= '0;
         word_sr  <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         sum      <= '0;
         csum_sr  <= '0;
         bad      <= 1'b0;
         top_q    <= '0;
         bottom_q <= '0;
         left_q   <= '0;
         right_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
      end else begin
         state    <= state_nx;
         window   <= window_nx;
         word_sr  <= word_sr_nx;
         bit_cnt  <= bit_cnt_nx;
         word_cnt <= word_cnt_nx;
         sum      <= sum_nx;
         csum_sr  <= csum_nx;
         bad      <= bad_nx;
         done_q   <= commit;
         err_q    <= reject;
         if (shadow_we) shadow[word_cnt] <= word_in;
         if (commit) begin
            for (int i = 0; i < NTB; i++) begin
               top_q[i*WORD_W +: WORD_W]    <= shadow[TOP_BASE + i];
               bottom_q[i*WORD_W +: WORD_W] <= shadow[BOTTOM_BASE + i];
            end
            for (int i = 0; i < NLR; i++) begin
               left_q[i*WORD_W +: WORD_W]   <= shadow[LEFT_BASE + i];
               right_q[i*WORD_W +: WORD_W]  <= shadow[RIGHT_BASE + i];
            end
         end
      end
   end

   assign bus.cfg_top    = top_q;
   assign bus.cfg_bottom = bottom_q;
   assign bus.cfg_left   = left_q;
   assign bus.cfg_right  = right_q;
   assign bus.cfg_done   = done_q;
   assign bus.cfg_err    = err_q;
   assign bus.cfg_busy   = (state != ST_HUNT);
   assign bus.dbg_state  = state;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed bench for switch_cfg_loader: frame-level model of the expected configuration and
// pulse timing, checked against the DUT outputs on every falling edge.
module tb_switch_cfg_loader;
   import switch_pkg::*;

   localparam int BIG = 32'h4000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   switch_cfg_loader_if bus ();

   switch_cfg_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   int   edge_cnt = 0;
   logic rst_q    = 1'b0;
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      rst_q    <= rst_n;
   end

   // Frame under construction and model expectations
   logic [5:0]  fw [NWORDS];
   logic [29:0] exp_top = '0, exp_bottom = '0;
   logic [23:0] exp_left = '0, exp_right = '0;
   logic [29:0] pend_top = '0, pend_bottom = '0;
   logic [23:0] pend_left = '0, pend_right = '0;
   bit          pend_good = 1'b0;
   int          pend_edge = -1;
   int          busy_from = BIG;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit word_ok(input logic [5:0] w);
      case (w[2:0])
         3'd0:       return 1'b1;
         3'd1, 3'd3: return w[5:3] <= 3'd4;
         3'd2, 3'd4: return w[5:3] <= 3'd3;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] frame_sum();
      int s = 0;
      for (int i = 0; i < NWORDS; i++) s += int'(fw[i]);
      return 8'(s % 256);
   endfunction

   task automatic clear_words();
      for (int i = 0; i < NWORDS; i++) fw[i] = '0;
   endtask

   task automatic drive_bit(input logic b, input bit stall, output int e);
      if (stall) begin
         for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
            bus.cfg_sen = 1'b0;
            bus.cfg_sdi = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
         end
      end
      bus.cfg_sen = 1'b1;
      bus.cfg_sdi = b;
      @(posedge clk);
      e = edge_cnt;
      #2;
      bus.cfg_sen = 1'b0;
   endtask

   task automatic send_sync(input bit stall, output int first_e);
      logic [7:0] s;
      int e;
      s = SYNC;
      first_e = 0;
      for (int i = 7; i >= 0; i--) begin
         drive_bit(s[i], stall, e);
         if (i == 7) first_e = e;
      end
      busy_from = e;
      pend_edge = BIG;
   endtask

   task automatic send_frame(input logic [7:0] cs, input bit stall, input bit dangle, output int first_e);
      int  e;
      bit  ok;
      send_sync(stall, first_e);
      e = 0;
      for (int w = 0; w < NWORDS; w++)
         for (int b = 5; b >= 0; b--) drive_bit(fw[w][b], stall, e);
      for (int i = 7; i >= 0; i--) drive_bit(cs[i], stall, e);
      ok = (cs == frame_sum());
      for (int w = 0; w < NWORDS; w++) if (!word_ok(fw[w])) ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pend_top[i*6 +: 6]    = fw[i];
         pend_bottom[i*6 +: 6] = fw[5 + i];
      end
      for (int i = 0; i < 4; i++) begin
         pend_left[i*6 +: 6]  = fw[10 + i];
         pend_right[i*6 +: 6] = fw[14 + i];
      end
      pend_good = ok;
      pend_edge = e + 1;
      if (dangle) begin
         bus.cfg_sen = 1'b1;
         bus.cfg_sdi = 1'b1;
         @(posedge clk);
         #2;
         bus.cfg_sen = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      busy_from = BIG;
      pend_edge = -1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic load_f1();
      clear_words();
      fw[0]  = 6'o11;
      fw[17] = 6'o34;
   endtask

   // Compare process: every falling edge, outputs against the frame-level model
   initial begin
      int  last;
      bit  e_done, e_err, e_busy;
      forever begin
         @(negedge clk);
         last = edge_cnt - 1;
         if (!rst_q) begin
            exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0;
         end else if (last == pend_edge && pend_good) begin
            exp_top = pend_top; exp_bottom = pend_bottom;
            exp_left = pend_left; exp_right = pend_right;
         end
         e_done = rst_q && (last == pend_edge) && pend_good;
         e_err  = rst_q && (last == pend_edge) && !pend_good;
         e_busy = rst_q && (last >= busy_from) && (last < pend_edge);
         chk("done",   32'(bus.cfg_done),   32'(e_done));
         chk("err",    32'(bus.cfg_err),    32'(e_err));
         chk("busy",   32'(bus.cfg_busy),   32'(e_busy));
         chk("top",    32'(bus.cfg_top),    32'(exp_top));
         chk("bottom", 32'(bus.cfg_bottom), 32'(exp_bottom));
         chk("left",   32'(bus.cfg_left),   32'(exp_left));
         chk("right",  32'(bus.cfg_right),  32'(exp_right));
      end
   end

   initial begin
      int first_e;
      int e;
      bus.cfg_sen = 1'b0;
      bus.cfg_sdi = 1'b0;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Valid frame, unstalled: done exactly 124 edges after the first SYNC bit
      load_f1();
      chk("pin_sum_f1", 32'(frame_sum()), 32'h25);
      send_frame(8'h25, 1'b0, 1'b0, first_e);
      @(posedge clk);
      #1;
      chk("done_latency", 32'(bus.cfg_done), 32'd1);
      chk("done_edge", 32'(edge_cnt - 1 - first_e), 32'd124);
      chk("pin_top", 32'(bus.cfg_top), 32'(30'o11));
      chk("pin_right", 32'(bus.cfg_right), 32'({6'o34, 18'd0}));
      idle(3);

      // Wrong checksum
      send_frame(8'h26, 1'b0, 1'b0, first_e);
      idle(3);

      // Out-of-range index on a right-side source
      load_f1();
      fw[10] = 6'o52;
      chk("pin_sum_bad", 32'(frame_sum()), 32'h4F);
      send_frame(8'h4F, 1'b0, 1'b0, first_e);
      idle(3);

      // Side code 6 is never legal
      load_f1();
      fw[7] = 6'o16;
      send_frame(8'h33, 1'b0, 1'b0, first_e);
      idle(3);
      chk("kept_top", 32'(bus.cfg_top), 32'(30'o11));

      // Reset in the middle of a frame, then a clean reload
      load_f1();
      send_sync(1'b0, first_e);
      for (int i = 0; i < 40; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, e);
      do_reset();
      chk("rst_top", 32'(bus.cfg_top), 32'd0);
      chk("rst_right", 32'(bus.cfg_right), 32'd0);
      chk("rst_busy", 32'(bus.cfg_busy), 32'd0);
      chk("rst_state", 32'(bus.dbg_state), 32'(ST_HUNT));
      send_frame(8'h25, 1'b0, 1'b0, first_e);
      idle(3);

      // Garbage then a fully populated frame with random stalls
      for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b1, e);
      for (int i = 0; i < 12; i++) drive_bit(1'b0, 1'b1, e);
      fw[0] = 6'o01; fw[1] = 6'o11; fw[2] = 6'o21; fw[3] = 6'o31; fw[4] = 6'o41;
      fw[5] = 6'o03; fw[6] = 6'o13; fw[7] = 6'o23; fw[8] = 6'o33; fw[9] = 6'o70;
      fw[10] = 6'o04; fw[11] = 6'o14; fw[12] = 6'o24; fw[13] = 6'o34;
      fw[14] = 6'o02; fw[15] = 6'o12; fw[16] = 6'o22; fw[17] = 6'o32;
      chk("pin_sum_f2", 32'(frame_sum()), 32'h41);
      send_frame(8'h41, 1'b1, 1'b0, first_e);
      idle(3);
      chk("f2_bottom4", 32'(bus.cfg_bottom[29:24]), 32'(6'o70));

      // Index 4 is one past the last left/right wire
      clear_words();
      fw[14] = 6'o42;
      send_frame(8'h22, 1'b0, 1'b0, first_e);
      idle(3);

      // Back-to-back: a bit offered during CHECK is dropped, next SYNC follows immediately
      load_f1();
      send_frame(8'h25, 1'b0, 1'b1, first_e);
      clear_words();
      fw[4]  = 6'o43;
      fw[13] = 6'o24;
      send_frame(8'h37, 1'b0, 1'b0, first_e);
      idle(3);
      chk("b2b_top4", 32'(bus.cfg_top[29:24]), 32'(6'o43));
      chk("b2b_top0", 32'(bus.cfg_top[5:0]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
